lcd_out_sched: RTL and testbench

- Sequences all traffic to the character-LCD controller port (WRITE/WRDATA/STATUS) on behalf of the CPU output path.
- Runs the power-up init command list, buffers CPU output characters in a FIFO, tracks the cursor on a 16x2 display, and inserts line-change and clear commands automatically.
- Sits between the CPU data-write path (output select) and the LCD controller.
- Replaces ad-hoc command shifting in the top level with one handshaked scheduler.

---
 rtl/lcd_out_sched.sv | 121 ++++++++++++
 tb/tb_lcd_out_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_out_sched.sv
// lcd_out_sched: sequences the LCD init list, then drains a character FIFO into the LCD controller.
// It tracks the cursor on a 2-line display and inserts line-change and clear commands as needed.
module lcd_out_sched #(
  parameter int DEPTH = 32,
  parameter int COLS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_rst,
  input  logic [7:0] ch_in,
  input  logic       ch_en,
  output logic       ch_full,
  input  logic       lcd_busy,
  output logic       lcd_wen,
  output logic [8:0] lcd_wdt,
  output logic       init_done,
  output logic [5:0] col,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NFULL = (AW+1)'(DEPTH);
  localparam logic [5:0] C1 = 6'(COLS);
  localparam logic [5:0] C2 = 6'(2 * COLS);
  localparam logic [44:0] INIT_LIST = {9'h080, 9'h006, 9'h001, 9'h00C, 9'h038};
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_GAP} state_t;
  typedef struct packed {
    logic [AW:0]   cnt;
    logic          full;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          ovf;
    logic [44:0]   st;
    logic [2:0]    rem;
    logic [5:0]    ncol;
    logic [5:0]    col;
    logic          done;
    logic [8:0]    wdt;
  } dp_t;
  state_t state_q, state_d;
  dp_t dp_q, dp_d;
  logic [7:0] mem [DEPTH];
  logic push, pop, pr, lo;
  logic [7:0] c;
  logic [26:0] ps;
  logic [2:0] pn;
  logic [5:0] pcol;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_INIT;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_ISSUE;
      S_IDLE:  state_d = pop ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = lcd_busy ? S_ISSUE : S_GAP;
      S_GAP:   state_d = (dp_q.rem != 3'd1 || pop) ? S_ISSUE : S_IDLE;
    endcase
    if (s_rst) state_d = S_INIT;
  end
  // a finished step list may pop the next char straight from GAP, giving one write per two cycles
  always_comb begin
    lcd_wen = state_q == S_ISSUE && !lcd_busy && !s_rst;
    pop = !s_rst && dp_q.cnt != '0 &&
          (state_q == S_IDLE || (state_q == S_GAP && dp_q.rem == 3'd1 && dp_q.done));
    push = ch_en && !dp_q.full && !s_rst;
  end
  // step list is built from the cursor the previous char will leave behind
  always_comb begin
    c = mem[dp_q.rp];
    pr = c != 8'h0A && c != 8'h0D;
    lo = dp_q.ncol < C1;
    ps = {18'd0, 1'b1, c};
    pn = 3'd1;
    pcol = dp_q.ncol + 6'd1;
    if (pr && dp_q.ncol == C2) begin
      ps = {1'b1, c, 9'h080, 9'h001}; pn = 3'd3; pcol = 6'd1;
    end else if (pr && dp_q.ncol == C1) begin
      ps = {9'd0, 1'b1, c, 9'h0C0}; pn = 3'd2; pcol = C1 + 6'd1;
    end else if (c == 8'h0A) begin
      ps = lo ? {18'd0, 9'h0C0} : {9'd0, 9'h080, 9'h001};
      pn = lo ? 3'd1 : 3'd2;
      pcol = lo ? C1 : 6'd0;
    end else if (c == 8'h0D) begin
      ps = {18'd0, lo ? 9'h080 : 9'h0C0};
      pcol = lo ? 6'd0 : C1;
    end
  end
  always_comb begin
    dp_d = dp_q;
    dp_d.cnt = dp_q.cnt + (AW+1)'(push) - (AW+1)'(pop);
    dp_d.full = dp_d.cnt == NFULL;
    if (push) dp_d.wp = dp_q.wp + AW'(1);
    if (pop) dp_d.rp = dp_q.rp + AW'(1);
    if (ch_en && dp_q.full) dp_d.ovf = 1'b1;
    if (lcd_wen) dp_d.wdt = dp_q.st[8:0];
    if (state_q == S_INIT) begin
      dp_d.st = INIT_LIST; dp_d.rem = 3'd5; dp_d.ncol = '0;
    end
    if (state_q == S_GAP) begin
      if (dp_q.rem == 3'd1) begin
        dp_d.col = dp_q.ncol; dp_d.done = 1'b1;
      end else begin
        dp_d.st = dp_q.st >> 9; dp_d.rem = dp_q.rem - 3'd1;
      end
    end
    if (pop) begin
      dp_d.st = {18'd0, ps}; dp_d.rem = pn; dp_d.ncol = pcol;
    end
    if (s_rst) dp_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) dp_q <= '0;
    else dp_q <= dp_d;
  always_ff @(posedge clk)
    if (push) mem[dp_q.wp] <= ch_in;
  assign ch_full = dp_q.full;
  assign lcd_wdt = lcd_wen ? dp_q.st[8:0] : dp_q.wdt;
  assign init_done = dp_q.done;
  assign col = dp_q.col;
  assign ovf = dp_q.ovf;
endmodule

// File: tb/tb_lcd_out_sched.sv
// tb_lcd_out_sched: scoreboard bench; a cursor model predicts every LCD write, a monitor checks them.
module tb_lcd_out_sched;
  localparam int COLS = 16;
  logic clk = 0, rst = 1, s_rst = 0, ch_en = 0, lcd_busy = 0;
  logic [7:0] ch_in = 0;
  logic ch_full, lcd_wen, init_done, ovf;
  logic [8:0] lcd_wdt;
  logic [5:0] col;
  int total = 0, bad = 0, cyc = 0, last_wen = -10, mcol = 0;
  bit rb = 0;
  logic busy_fix = 0;
  logic [8:0] exp_q[$];
  int wen_cyc[$];
  lcd_out_sched #(.DEPTH(32), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .s_rst(s_rst), .ch_in(ch_in), .ch_en(ch_en),
    .ch_full(ch_full), .lcd_busy(lcd_busy), .lcd_wen(lcd_wen), .lcd_wdt(lcd_wdt),
    .init_done(init_done), .col(col), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endfunction
  // display behaviour: 2 lines of COLS, wrap to line 2, clear+home after line 2
  function automatic void model(logic [7:0] c);
    if (c == 8'h0A) begin
      if (mcol < COLS) begin exp_q.push_back(9'h0C0); mcol = COLS; end
      else begin exp_q.push_back(9'h001); exp_q.push_back(9'h080); mcol = 0; end
    end else if (c == 8'h0D) begin
      if (mcol < COLS) begin exp_q.push_back(9'h080); mcol = 0; end
      else begin exp_q.push_back(9'h0C0); mcol = COLS; end
    end else begin
      if (mcol == 2 * COLS) begin exp_q.push_back(9'h001); exp_q.push_back(9'h080); mcol = 0; end
      else if (mcol == COLS) exp_q.push_back(9'h0C0);
      exp_q.push_back({1'b1, c});
      mcol++;
    end
  endfunction
  function automatic void load_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
    exp_q.push_back(9'h006); exp_q.push_back(9'h080);
  endfunction
  always @(negedge clk) if (!rst && lcd_wen) begin
    logic [8:0] e;
    wen_cyc.push_back(cyc);
    chk("wen_busy", int'(lcd_busy), 0);
    chk("wen_gap", int'(cyc - last_wen >= 2), 1);
    last_wen = cyc;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_wen: got %0h want none", lcd_wdt);
    end else begin
      e = exp_q.pop_front();
      chk("wdt", int'(lcd_wdt), int'(e));
    end
  end
  task automatic tick();
    @(posedge clk); #1;
    lcd_busy = rb ? ($urandom_range(0, 9) < 3) : busy_fix;
  endtask
  task automatic push(input logic [7:0] c, input bit mdl);
    ch_in = c; ch_en = 1;
    if (mdl) model(c);
    tick();
    ch_en = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin tick(); n++; end
    chk("drain", exp_q.size(), 0);
    repeat (4) tick();
  endtask
  function automatic logic [7:0] rand_pr();
    return 8'($urandom_range(32, 126));
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int r, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", int'(lcd_wen), 0);
    chk("rst_wdt", int'(lcd_wdt), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_full", int'(ch_full), 0);
    load_init();
    wen_cyc.delete();
    r = cyc;
    rst = 0;
    drain();
    chk("init_n", wen_cyc.size(), 5);
    for (int i = 0; i < 5 && i < wen_cyc.size(); i++) chk("init_cyc", wen_cyc[i] - r, 1 + 2 * i);
    chk("init_done", int'(init_done), 1);
    chk("init_col", int'(col), 0);
    wen_cyc.delete();
    n = cyc;
    push(8'h41, 1);
    drain();
    chk("lat", wen_cyc.size() > 0 ? wen_cyc[0] - n : -1, 2);
    chk("col_A", int'(col), 1);
    wen_cyc.delete();
    push(8'h0D, 1);
    for (int i = 0; i < 17; i++) push(8'h61 + 8'(i), 1);
    drain();
    chk("b2b", wen_cyc.size() > 16 ? wen_cyc[16] - wen_cyc[1] : -1, 30);
    chk("col_q", int'(col), 17);
    for (int i = 0; i < 15; i++) push(rand_pr(), 1);
    drain();
    chk("col_32", int'(col), 32);
    push(8'h5A, 1);
    drain();
    chk("col_Z", int'(col), 1);
    for (int i = 0; i < 4; i++) push(rand_pr(), 1);
    push(8'h0A, 1);
    drain();
    chk("col_lf", int'(col), 16);
    push(8'h0D, 1);
    drain();
    chk("col_cr", int'(col), 16);
    busy_fix = 1;
    tick();
    wen_cyc.delete();
    for (int i = 0; i < 33; i++) push(rand_pr(), 1);
    chk("full", int'(ch_full), 1);
    chk("stall_wen", wen_cyc.size(), 0);
    push(8'h21, 0);
    chk("ovf", int'(ovf), 1);
    busy_fix = 0;
    drain();
    chk("full_clr", int'(ch_full), 0);
    chk("ovf_hold", int'(ovf), 1);
    chk("col_stall", int'(col), mcol);
    if (mcol < COLS) begin push(8'h0A, 1); drain(); end
    busy_fix = 1;
    tick();
    push(8'h0A, 1);
    push(8'h78, 0);
    push(8'h79, 0);
    busy_fix = 0;
    lcd_busy = 0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (lcd_wen && lcd_wdt == 9'h001) break;
    end
    chk("saw_001", int'(n < 50), 1);
    @(posedge clk); #1;
    s_rst = 1;
    exp_q.delete();
    load_init();
    mcol = 0;
    tick();
    s_rst = 0;
    chk("srst_full", int'(ch_full), 0);
    chk("srst_ovf", int'(ovf), 0);
    chk("srst_done", int'(init_done), 0);
    chk("srst_col", int'(col), 0);
    drain();
    repeat (20) tick();
    chk("reinit_done", int'(init_done), 1);
    chk("reinit_col", int'(col), 0);
    rb = 1;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(5, 25);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        push(r == 0 ? 8'h0A : r == 1 ? 8'h0D : rand_pr(), 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      chk("col_rand", int'(col), mcol);
    end
    rb = 0;
    repeat (10) tick();
    chk("exp_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
